// File: rtl/bus_arbiter_4.sv
// bus_arbiter_4: round-robin arbiter that shares one 16-bit datapath between
// four requesters. It drives a registered one-hot grant and a registered 2-bit
// mux select. Ownership lasts while the owner holds its request, and each
// handover is followed by a TURN dead cycle.
// Optional watchdog: define NEPTUNE_ARB_WATCHDOG_EN to revoke ownership after
// max_hold consecutive BUSY cycles.
module bus_arbiter_4 #(
  parameter int unsigned max_hold = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic       busy_q, busy_d;

  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       hold_expired;

  // rotating-priority search: first set request after last, wrapping to last
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    idx    = last_q;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

`ifdef NEPTUNE_ARB_WATCHDOG_EN
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  // hold counter: zero outside BUSY, so it is already cleared on entry
  always_comb begin
    hold_d       = (state_q == BUSY) ? hold_q + 8'd1 : 8'd0;
    hold_expired = (hold_q == 8'(max_hold - 1));
    timeout_d    = (state_q == BUSY) && req[sel_q] && hold_expired;
  end

  // watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // no watchdog: never expires (max_hold is legal from 2 upward, so this is 0)
  always_comb begin
    hold_expired = (max_hold == 0);
  end

  assign timeout = 1'b0;
`endif

  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          last_d  = winner;
          busy_d  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // release and revocation look the same on the bus; last keeps the owner
        if (!req[sel_q] || hold_expired) begin
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
          state_d = TURN;
        end
      end
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register; sel is only ever reloaded at a new grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule
